// File: rtl/ddc_cfg_pkg.sv
// ddc_cfg_pkg: word counts, widths and FSM encodings shared by the DDC config controller and receivers
package ddc_cfg_pkg;
  localparam int CONFIG_WIDTH         = 32;
  localparam int CICC_COEFF_WIDTH     = 24;
  localparam int FILTER_ORDER         = 256;
  localparam int ADDR_WIDTH           = 9;
  localparam int CNT_WIDTH            = 10;
  localparam int CICC_CONFIG_DATA_NUM = FILTER_ORDER + 3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_COEF,
    ST_LOAD_SCALE,
    ST_LOAD_SYM,
    ST_WAIT_SWAP,
    ST_FIN
  } cicc_cfg_state_e;
endpackage

// File: rtl/cicc_coef_bank_ram.sv
// cicc_coef_bank_ram: two-bank coefficient RAM, writes go to the shadow bank, registered reads from the active bank
module cicc_coef_bank_ram
  import ddc_cfg_pkg::*;
(
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        bank_sel,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [CICC_COEFF_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [CICC_COEFF_WIDTH-1:0] rd_data
);
  logic [CICC_COEFF_WIDTH-1:0] mem_q [2**(ADDR_WIDTH+1)];
  always_ff @(posedge CLK)
    if (wr_en) mem_q[{~bank_sel, wr_addr}] <= wr_data;
  // Addresses past the last tap read as zero so the FIR engine can run a padded index range
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) rd_data <= '0;
    else rd_data <= (rd_addr > ADDR_WIDTH'(FILTER_ORDER)) ? '0 : mem_q[{bank_sel, rd_addr}];
endmodule

// File: rtl/cicc_coef_cfg_rx.sv
// cicc_coef_cfg_rx: receives a CICC coefficient set into a shadow bank and activates it at a filter-safe boundary
module cicc_coef_cfg_rx
  import ddc_cfg_pkg::*;
(
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        isConfig,
  input  logic [CONFIG_WIDTH-1:0]     Data_Config_In,
  output logic                        isConfigACK,
  output logic                        isConfigDone,
  output logic                        isConfigErr,
  input  logic                        Swap_En,
  input  logic [ADDR_WIDTH-1:0]       Coef_Rd_Addr,
  output logic [CICC_COEFF_WIDTH-1:0] Coef_Rd_Data,
  output logic [CICC_COEFF_WIDTH-1:0] Coef_Scale,
  output logic                        Coef_Sym,
  output logic                        Cfg_Valid
);
  cicc_cfg_state_e             state_q;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic                        bank_sel_q;
  logic [CICC_COEFF_WIDTH-1:0] shadow_scale_q;
  logic                        shadow_sym_q;
  logic                        busy;
  logic                        wr_en;
  logic                        unused_hi;
  assign busy      = state_q inside {ST_LOAD_COEF, ST_LOAD_SCALE, ST_LOAD_SYM, ST_WAIT_SWAP};
  assign wr_en     = state_q == ST_LOAD_COEF && !isConfig;
  assign unused_hi = ^Data_Config_In[CONFIG_WIDTH-1:CICC_COEFF_WIDTH];
  cicc_coef_bank_ram u_ram (
    .CLK     (CLK),
    .nRST    (nRST),
    .bank_sel(bank_sel_q),
    .wr_en   (wr_en),
    .wr_addr (cnt_q[ADDR_WIDTH-1:0]),
    .wr_data (Data_Config_In[CICC_COEFF_WIDTH-1:0]),
    .rd_addr (Coef_Rd_Addr),
    .rd_data (Coef_Rd_Data)
  );
  // A start during any load/wait state aborts and restarts; a start in FIN is an ordinary new load
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bank_sel_q     <= 1'b0;
      shadow_scale_q <= '0;
      shadow_sym_q   <= 1'b0;
      isConfigACK    <= 1'b0;
      isConfigDone   <= 1'b0;
      isConfigErr    <= 1'b0;
      Coef_Scale     <= '0;
      Coef_Sym       <= 1'b0;
      Cfg_Valid      <= 1'b0;
    end else begin
      isConfigDone <= 1'b0;
      isConfigErr  <= 1'b0;
      if (isConfig) begin
        state_q     <= ST_LOAD_COEF;
        cnt_q       <= '0;
        isConfigACK <= 1'b1;
        isConfigErr <= busy;
      end else begin
        case (state_q)
          ST_LOAD_COEF: begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(FILTER_ORDER)) state_q <= ST_LOAD_SCALE;
          end
          ST_LOAD_SCALE: begin
            shadow_scale_q <= Data_Config_In[CICC_COEFF_WIDTH-1:0];
            state_q        <= ST_LOAD_SYM;
          end
          ST_LOAD_SYM: begin
            shadow_sym_q <= Data_Config_In[0];
            state_q      <= ST_WAIT_SWAP;
          end
          ST_WAIT_SWAP:
            if (Swap_En) begin
              bank_sel_q   <= ~bank_sel_q;
              Coef_Scale   <= shadow_scale_q;
              Coef_Sym     <= shadow_sym_q;
              Cfg_Valid    <= 1'b1;
              isConfigDone <= 1'b1;
              state_q      <= ST_FIN;
            end
          ST_FIN: begin
            isConfigACK <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
endmodule
